mips_id_stage: RTL and testbench

- Instruction-decode stage of the 5-stage MIPS pipeline: the producer end of the ALU control interface.
- Decodes a 32-bit instruction into ALUOp, func and shift_amt, plus memory/writeback controls and the A/B operands the execute stage consumes.
- Holds the results in the ID/EX pipeline register.
- Detects load-use hazards against its own registered contents; handles stall, bubble insertion, flush and downstream hold.

---
 rtl/mips_id_stage.sv | 173 +++++++++++++++++
 tb/tb_mips_id_stage.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_id_stage.sv
// Instruction-decode stage of the 5-stage MIPS pipeline.
// Decodes the IF/ID instruction into ALU control, memory/writeback controls
// and operands, registers them in ID/EX, and resolves load-use hazards,
// flushes and downstream hold.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   if_valid, instr fetched instruction from IF/ID
//   flush           kill the instruction in ID (branch taken)
//   ex_hold         execute stage busy; freeze ID/EX
//   rs_addr/rt_addr register-file read addresses (combinational)
//   rs_data/rt_data register-file read data (same cycle)
//   stall           IF/ID hold request (combinational)
//   illegal         sticky unsupported-opcode flag
//   ex_valid .. write_reg  registered ID/EX contents
module mips_id_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [31:0]       instr,
    input  logic              flush,
    input  logic              ex_hold,
    output logic [REG_AW-1:0] rs_addr,
    output logic [REG_AW-1:0] rt_addr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    output logic              stall,
    output logic              illegal,
    output logic              ex_valid,
    output logic [1:0]        alu_op,
    output logic [5:0]        func,
    output logic [4:0]        shift_amt,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [DATA_W-1:0] store_data,
    output logic              reg_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic              branch,
    output logic [REG_AW-1:0] write_reg
);

    localparam int unsigned OPC_W  = 6;
    localparam int unsigned IMM_W  = 16;

    localparam logic [OPC_W-1:0] OPC_RTYPE = 6'd0;
    localparam logic [OPC_W-1:0] OPC_BEQ   = 6'd4;
    localparam logic [OPC_W-1:0] OPC_LW    = 6'd35;
    localparam logic [OPC_W-1:0] OPC_SW    = 6'd43;

    localparam logic [1:0] ALU_MEM = 2'b00;
    localparam logic [1:0] ALU_BEQ = 2'b01;
    localparam logic [1:0] ALU_R   = 2'b10;

    logic [OPC_W-1:0]  opcode;
    logic [REG_AW-1:0] rd_addr;
    logic [DATA_W-1:0] imm_sext;
    logic              is_r, is_lw, is_sw, is_beq, legal, uses_rt;
    logic              hazard, load_instr, set_illegal;

    logic              d_valid, d_reg_write, d_mem_read, d_mem_write, d_branch;
    logic [1:0]        d_alu_op;
    logic [5:0]        d_func;
    logic [4:0]        d_shift_amt;
    logic [DATA_W-1:0] d_a, d_b, d_store;
    logic [REG_AW-1:0] d_write_reg;

    // Field extraction and opcode classification
    always_comb begin
        opcode   = instr[31:26];
        rs_addr  = REG_AW'(instr[25:21]);
        rt_addr  = REG_AW'(instr[20:16]);
        rd_addr  = REG_AW'(instr[15:11]);
        imm_sext = {{(DATA_W-IMM_W){instr[15]}}, instr[15:0]};
        is_r     = (opcode == OPC_RTYPE);
        is_lw    = (opcode == OPC_LW);
        is_sw    = (opcode == OPC_SW);
        is_beq   = (opcode == OPC_BEQ);
        legal    = is_r | is_lw | is_sw | is_beq;
        // lw writes rt rather than reading it, so only these read rt
        uses_rt  = is_r | is_sw | is_beq;
    end

    // Load-use hazard against the load currently held in ID/EX
    always_comb begin
        hazard = ex_valid & mem_read & (write_reg != '0) & if_valid &
                 ((write_reg == rs_addr) | (uses_rt & (write_reg == rt_addr)));
        stall       = (ex_hold & if_valid) | (hazard & ~flush);
        load_instr  = ~ex_hold & ~flush & ~hazard & if_valid;
        set_illegal = load_instr & ~legal;
    end

    // Next ID/EX contents; anything not loaded as a legal instruction is a bubble
    always_comb begin
        d_valid     = 1'b0;
        d_alu_op    = 2'b00;
        d_func      = 6'd0;
        d_shift_amt = 5'd0;
        d_a         = '0;
        d_b         = '0;
        d_store     = '0;
        d_reg_write = 1'b0;
        d_mem_read  = 1'b0;
        d_mem_write = 1'b0;
        d_branch    = 1'b0;
        d_write_reg = '0;
        if (load_instr && legal) begin
            d_valid = 1'b1;
            d_a     = rs_data;
            d_b     = rt_data;
            d_store = rt_data;
            if (is_r) begin
                d_alu_op    = ALU_R;
                d_func      = instr[5:0];
                d_shift_amt = instr[10:6];
                d_reg_write = 1'b1;
                d_write_reg = rd_addr;
            end else if (is_lw) begin
                d_alu_op    = ALU_MEM;
                d_b         = imm_sext;
                d_mem_read  = 1'b1;
                d_reg_write = 1'b1;
                d_write_reg = rt_addr;
            end else if (is_sw) begin
                d_alu_op    = ALU_MEM;
                d_b         = imm_sext;
                d_mem_write = 1'b1;
            end else begin
                d_alu_op = ALU_BEQ;
                d_branch = 1'b1;
            end
        end
    end

    // ID/EX pipeline register; frozen while execute holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid   <= 1'b0;
            alu_op     <= 2'b00;
            func       <= 6'd0;
            shift_amt  <= 5'd0;
            a_out      <= '0;
            b_out      <= '0;
            store_data <= '0;
            reg_write  <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            branch     <= 1'b0;
            write_reg  <= '0;
            illegal    <= 1'b0;
        end else begin
            illegal <= illegal | set_illegal;
            if (!ex_hold) begin
                ex_valid   <= d_valid;
                alu_op     <= d_alu_op;
                func       <= d_func;
                shift_amt  <= d_shift_amt;
                a_out      <= d_a;
                b_out      <= d_b;
                store_data <= d_store;
                reg_write  <= d_reg_write;
                mem_read   <= d_mem_read;
                mem_write  <= d_mem_write;
                branch     <= d_branch;
                write_reg  <= d_write_reg;
            end
        end
    end

endmodule

// File: tb/tb_mips_id_stage.sv
// Directed bench for mips_id_stage: decode, load-use stall, flush, hold,
// illegal opcode and asynchronous reset.
module tb_mips_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] instr;
    logic        flush;
    logic        ex_hold;
    logic [4:0]  rs_addr, rt_addr;
    logic [31:0] rs_data, rt_data;
    logic        stall, illegal, ex_valid;
    logic [1:0]  alu_op;
    logic [5:0]  func;
    logic [4:0]  shift_amt;
    logic [31:0] a_out, b_out, store_data;
    logic        reg_write, mem_read, mem_write, branch;
    logic [4:0]  write_reg;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] I_ADD = 32'h0022_1820; // add $3,$1,$2
    localparam logic [31:0] I_LW  = 32'h8C22_0004; // lw  $2,4($1)
    localparam logic [31:0] I_SLL = 32'h0002_20C0; // sll $4,$2,3
    localparam logic [31:0] I_SW  = 32'hAC22_FFF8; // sw  $2,-8($1)
    localparam logic [31:0] I_BEQ = 32'h1040_0003; // beq $2,$0,3
    localparam logic [31:0] I_SUB = 32'h0062_2022; // sub $4,$3,$2
    localparam logic [31:0] I_ILL = 32'hFC00_0000; // opcode 0x3F

    always #5 clk = ~clk;

    mips_id_stage dut (
        .clk        (clk),
        .rst        (rst),
        .if_valid   (if_valid),
        .instr      (instr),
        .flush      (flush),
        .ex_hold    (ex_hold),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .stall      (stall),
        .illegal    (illegal),
        .ex_valid   (ex_valid),
        .alu_op     (alu_op),
        .func       (func),
        .shift_amt  (shift_amt),
        .a_out      (a_out),
        .b_out      (b_out),
        .store_data (store_data),
        .reg_write  (reg_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .branch     (branch),
        .write_reg  (write_reg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle away from it
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        if_valid = v;
        instr    = i;
        rs_data  = a;
        rt_data  = b;
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(ex_valid), 32'd0);
        chk({tag, "_ctl"}, 32'({alu_op, reg_write, mem_read, mem_write, branch}), 32'd0);
        chk({tag, "_fields"}, 32'({func, shift_amt, write_reg}), 32'd0);
        chk({tag, "_data"}, a_out | b_out | store_data, 32'd0);
        chk({tag, "_illegal"}, 32'(illegal), 32'd0);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
    endtask

    initial begin
        rst = 1'b1; if_valid = 1'b0; instr = 32'd0; flush = 1'b0; ex_hold = 1'b0;
        rs_data = 32'd0; rt_data = 32'd0;
        cyc(); cyc();
        chk_all_zero("reset");
        rst = 1'b0;

        // R-type add
        drive(1'b1, I_ADD, 32'd5, 32'd7);
        chk("add_rs_addr", 32'(rs_addr), 32'd1);
        chk("add_rt_addr", 32'(rt_addr), 32'd2);
        chk("add_stall_pre", 32'(stall), 32'd0);
        cyc();
        chk("add_valid", 32'(ex_valid), 32'd1);
        chk("add_alu_op", 32'(alu_op), 32'd2);
        chk("add_func", 32'(func), 32'd32);
        chk("add_a", a_out, 32'd5);
        chk("add_b", b_out, 32'd7);
        chk("add_regw", 32'(reg_write), 32'd1);
        chk("add_wreg", 32'(write_reg), 32'd3);

        // lw followed by dependent sll: one bubble
        drive(1'b1, I_LW, 32'd10, 32'd99);
        cyc();
        chk("lw_alu_op", 32'(alu_op), 32'd0);
        chk("lw_b", b_out, 32'd4);
        chk("lw_a", a_out, 32'd10);
        chk("lw_mem_read", 32'(mem_read), 32'd1);
        chk("lw_regw", 32'(reg_write), 32'd1);
        chk("lw_wreg", 32'(write_reg), 32'd2);
        drive(1'b1, I_SLL, 32'd0, 32'd11);
        chk("sll_stall", 32'(stall), 32'd1);
        cyc();
        chk("bubble_valid", 32'(ex_valid), 32'd0);
        chk("bubble_mem_read", 32'(mem_read), 32'd0);
        chk("bubble_wreg", 32'(write_reg), 32'd0);
        chk("bubble_stall_drop", 32'(stall), 32'd0);
        cyc();
        chk("sll_valid", 32'(ex_valid), 32'd1);
        chk("sll_func", 32'(func), 32'd0);
        chk("sll_shamt", 32'(shift_amt), 32'd3);
        chk("sll_wreg", 32'(write_reg), 32'd4);

        // sw with negative offset
        drive(1'b1, I_SW, 32'd100, 32'h0000_1234);
        cyc();
        chk("sw_b", b_out, 32'hFFFF_FFF8);
        chk("sw_mem_write", 32'(mem_write), 32'd1);
        chk("sw_regw", 32'(reg_write), 32'd0);
        chk("sw_wreg", 32'(write_reg), 32'd0);
        chk("sw_store", store_data, 32'h0000_1234);

        // beq without hazard
        drive(1'b1, I_BEQ, 32'd8, 32'd9);
        cyc();
        chk("beq_alu_op", 32'(alu_op), 32'd1);
        chk("beq_branch", 32'(branch), 32'd1);
        chk("beq_b", b_out, 32'd9);
        chk("beq_wreg", 32'(write_reg), 32'd0);

        // lw then hazarding beq killed by flush
        drive(1'b1, I_LW, 32'd10, 32'd99);
        cyc();
        drive(1'b1, I_BEQ, 32'd8, 32'd9);
        chk("beq_haz_stall", 32'(stall), 32'd1);
        flush = 1'b1;
        #1;
        chk("flush_stall", 32'(stall), 32'd0);
        cyc();
        flush = 1'b0;
        chk("flush_valid", 32'(ex_valid), 32'd0);
        chk("flush_branch", 32'(branch), 32'd0);

        // Illegal opcode: sticky flag, bubble
        drive(1'b1, I_ILL, 32'd1, 32'd2);
        cyc();
        chk("ill_flag", 32'(illegal), 32'd1);
        chk("ill_valid", 32'(ex_valid), 32'd0);

        // Hold for three cycles with add loaded
        drive(1'b1, I_ADD, 32'd5, 32'd7);
        cyc();
        chk("ill_sticky", 32'(illegal), 32'd1);
        chk("add2_valid", 32'(ex_valid), 32'd1);
        ex_hold = 1'b1;
        drive(1'b1, I_SUB, 32'd20, 32'd3);
        chk("hold_stall", 32'(stall), 32'd1);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("hold_func", 32'(func), 32'd32);
            chk("hold_wreg", 32'(write_reg), 32'd3);
            chk("hold_a", a_out, 32'd5);
            chk("hold_stall_cyc", 32'(stall), 32'd1);
        end
        ex_hold = 1'b0;
        #1;
        chk("release_stall", 32'(stall), 32'd0);
        cyc();
        chk("sub_func", 32'(func), 32'h22);
        chk("sub_wreg", 32'(write_reg), 32'd4);
        chk("sub_a", a_out, 32'd20);

        // No valid instruction: bubble
        drive(1'b0, I_ADD, 32'd5, 32'd7);
        cyc();
        chk("idle_valid", 32'(ex_valid), 32'd0);
        chk("idle_regw", 32'(reg_write), 32'd0);

        // Reset in the middle of a load-use stall
        drive(1'b1, I_LW, 32'd10, 32'd99);
        cyc();
        drive(1'b1, I_SLL, 32'd0, 32'd11);
        chk("pre_rst_stall", 32'(stall), 32'd1);
        rst = 1'b1;
        #1;
        chk_all_zero("mid_rst");
        cyc();
        chk_all_zero("rst_held");
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
